// File: rtl/subsurf_pkg.sv
// Shared types and constants for the subdivision-surface controller.
// FSM state enum, default RAM address width, bank count, start pulse length.
package subsurf_pkg;

  localparam int ADDR_W    = 9;
  localparam int NBANK     = 3;
  localparam int START_LEN = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FIN
  } state_t;

endpackage

// File: rtl/subsurf_ctrl_ram_port_mux.sv
// Combinational RAM port mux: engine buses when eng_owns, else one host bank.
// Ports: eng_owns/host_sel selects, host_* access, eng_* buses, ram_* outputs.
module ram_port_mux
  import subsurf_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic                  eng_owns,
  input  logic                  host_sel,
  input  logic [1:0]            host_bank,
  input  logic [AW-1:0]         host_addr,
  input  logic [3:0]            host_we,
  input  logic [31:0]           host_wdata,
  input  logic [NBANK-1:0]      eng_en,
  input  logic [NBANK*AW-1:0]   eng_a,
  input  logic [4*NBANK-1:0]    eng_we,
  input  logic [32*NBANK-1:0]   eng_di,
  output logic [NBANK-1:0]      ram_en,
  output logic [NBANK*AW-1:0]   ram_a,
  output logic [4*NBANK-1:0]    ram_we,
  output logic [32*NBANK-1:0]   ram_di
);

  always_comb begin
    ram_en = '0;
    ram_a  = '0;
    ram_we = '0;
    ram_di = '0;
    if (eng_owns) begin
      ram_en = eng_en;
      ram_a  = eng_a;
      ram_we = eng_we;
      ram_di = eng_di;
    end else if (host_sel) begin
      // bank 3 matches no slice, so it is a no-op access
      for (int k = 0; k < NBANK; k++) begin
        if (host_bank == 2'(k)) begin
          ram_en[k]            = 1'b1;
          ram_a[k*AW +: AW]    = host_addr;
          ram_we[k*4 +: 4]     = host_we;
          ram_di[k*32 +: 32]   = host_wdata;
        end
      end
    end
  end

endmodule

// File: rtl/subsurf_ctrl.sv
// Subdivision run controller: launches engine passes, arbitrates RAM access.
// Ports: cmd_*, busy/done/err, host_* RAM access, eng_* engine, ram_* RAMs.
// Optional watchdog on WAIT enabled by define SUBSURF_WATCHDOG_EN.
module subsurf_ctrl
  import subsurf_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int WD_CYCLES  = 65535
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  input  logic [2:0]                  cmd_levels,
  output logic                        cmd_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  input  logic                        host_req,
  input  logic [1:0]                  host_bank,
  input  logic [ADDR_WIDTH-1:0]       host_addr,
  input  logic [3:0]                  host_we,
  input  logic [31:0]                 host_wdata,
  output logic                        host_gnt,
  output logic [31:0]                 host_rdata,
  output logic                        host_rvalid,
  output logic                        eng_start,
  input  logic                        eng_busy,
  input  logic [NBANK-1:0]            eng_en,
  input  logic [NBANK*ADDR_WIDTH-1:0] eng_a,
  input  logic [4*NBANK-1:0]          eng_we,
  input  logic [32*NBANK-1:0]         eng_di,
  output logic [NBANK-1:0]            ram_en,
  output logic [NBANK*ADDR_WIDTH-1:0] ram_a,
  output logic [4*NBANK-1:0]          ram_we,
  output logic [32*NBANK-1:0]         ram_di,
  input  logic [32*NBANK-1:0]         ram_do
);

  state_t      state;
  state_t      state_nx;
  logic [2:0]  lvl;
  logic [1:0]  lcnt;
  logic        idle_open;
  logic        eng_owns;
  logic        rd_go;
  logic        wd_hit;
  logic [31:0] rd_slice;

  // the done cycle is already IDLE; keep it closed so the
  // host is served only on the cycle after done
  assign idle_open = (state == S_IDLE) && !done;
  assign host_gnt  = rst_n && idle_open && host_req;
  assign cmd_ready = rst_n && idle_open && cmd_valid && !host_req;
  assign busy      = (state != S_IDLE);
  assign eng_start = (state == S_LAUNCH);
  assign eng_owns  = rst_n && (state == S_LAUNCH || state == S_WAIT);
  assign rd_go     = host_gnt && (host_we == 4'h0);

  always_comb begin
    rd_slice = '0;
    for (int k = 0; k < NBANK; k++) begin
      if (host_bank == 2'(k)) rd_slice = ram_do[k*32 +: 32];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (cmd_ready)
          state_nx = (cmd_levels == 3'd0) ? S_FIN : S_LAUNCH;
      end
      S_LAUNCH: begin
        if (lcnt == 2'(START_LEN - 1)) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (!eng_busy)
          state_nx = (lvl == 3'd1) ? S_FIN : S_LAUNCH;
        else if (wd_hit)
          state_nx = S_IDLE;
      end
      S_FIN: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lvl         <= '0;
      lcnt        <= '0;
      done        <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state       <= state_nx;
      done        <= (state == S_FIN);
      host_rvalid <= rd_go;
      if (rd_go) host_rdata <= rd_slice;
      lcnt <= (state == S_LAUNCH) ? lcnt + 2'd1 : 2'd0;
      if (cmd_ready)
        lvl <= cmd_levels;
      else if (state == S_WAIT && !eng_busy)
        lvl <= lvl - 3'd1;
    end
  end

`ifdef SUBSURF_WATCHDOG_EN
  localparam int WDW = $clog2(WD_CYCLES + 1);

  logic [WDW-1:0] wd_cnt;
  logic           err_q;

  assign wd_hit = (state == S_WAIT) && eng_busy &&
                  (wd_cnt == WDW'(WD_CYCLES - 1));
  assign err    = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= (state == S_WAIT && eng_busy) ?
                wd_cnt + WDW'(1) : '0;
      if (cmd_ready)   err_q <= 1'b0;
      else if (wd_hit) err_q <= 1'b1;
    end
  end
`else
  logic unused_wd;

  assign wd_hit    = 1'b0;
  assign err       = 1'b0;
  assign unused_wd = (WD_CYCLES > 0);
`endif

  ram_port_mux #(
    .AW(ADDR_WIDTH)
  ) u_mux (
    .eng_owns   (eng_owns),
    .host_sel   (host_gnt),
    .host_bank  (host_bank),
    .host_addr  (host_addr),
    .host_we    (host_we),
    .host_wdata (host_wdata),
    .eng_en     (eng_en),
    .eng_a      (eng_a),
    .eng_we     (eng_we),
    .eng_di     (eng_di),
    .ram_en     (ram_en),
    .ram_a      (ram_a),
    .ram_we     (ram_we),
    .ram_di     (ram_di)
  );

endmodule

// File: tb/tb_subsurf_ctrl.sv
// Directed bench for subsurf_ctrl with RAM and engine models.
// Watchdog steps are included when SUBSURF_WATCHDOG_EN is defined.
module tb_subsurf_ctrl;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic [2:0]    cmd_levels;
  logic          cmd_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic          host_req;
  logic [1:0]    host_bank;
  logic [AW-1:0] host_addr;
  logic [3:0]    host_we;
  logic [31:0]   host_wdata;
  logic          host_gnt;
  logic [31:0]   host_rdata;
  logic          host_rvalid;
  logic          eng_start;
  logic          eng_busy;
  logic [2:0]    eng_en;
  logic [3*AW-1:0] eng_a;
  logic [11:0]   eng_we;
  logic [95:0]   eng_di;
  logic [2:0]    ram_en;
  logic [3*AW-1:0] ram_a;
  logic [11:0]   ram_we;
  logic [95:0]   ram_di;
  logic [95:0]   ram_do;

  int n_cmp = 0;
  int n_err = 0;

  logic        eng_busy_m = 1'b0;
  int          eng_cnt = 0;
  logic        eng_stuck;
  logic [31:0] mem [3][512];

  always #5 clk = ~clk;

  subsurf_ctrl #(
    .ADDR_WIDTH(AW),
    .WD_CYCLES (16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_levels(cmd_levels),
    .cmd_ready(cmd_ready),
    .busy(busy), .done(done), .err(err),
    .host_req(host_req), .host_bank(host_bank),
    .host_addr(host_addr), .host_we(host_we),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .eng_start(eng_start), .eng_busy(eng_busy),
    .eng_en(eng_en), .eng_a(eng_a),
    .eng_we(eng_we), .eng_di(eng_di),
    .ram_en(ram_en), .ram_a(ram_a),
    .ram_we(ram_we), .ram_di(ram_di),
    .ram_do(ram_do)
  );

  // RAM model: byte-write, asynchronous read
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ram_en[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_we[k*4+b])
            mem[k][ram_a[k*AW +: AW]][b*8 +: 8] <=
              ram_di[k*32 + b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    ram_do = '0;
    for (int k = 0; k < 3; k++)
      ram_do[k*32 +: 32] = mem[k][ram_a[k*AW +: AW]];
  end

  // engine model: busy for 10 edges after the last start
  always @(posedge clk) begin
    if (eng_start) begin
      eng_busy_m <= 1'b1;
      eng_cnt    <= 10;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) eng_busy_m <= 1'b0;
    end
  end

  assign eng_busy = eng_busy_m | eng_stuck;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // walk a run cycle by cycle until done, collecting observations
  task automatic run_until_done(input int limit,
                                output int ncyc,
                                output int nstart,
                                output int nrun,
                                output int nbadlen,
                                output int nbad);
    int rl;
    rl = 0;
    ncyc = -1;
    nstart = 0;
    nrun = 0;
    nbadlen = 0;
    nbad = 0;
    for (int i = 0; i < limit; i++) begin
      if (eng_start) begin
        nstart++;
        rl++;
      end else if (rl != 0) begin
        nrun++;
        if (rl != 3) nbadlen++;
        rl = 0;
      end
      if (host_gnt || cmd_ready) nbad++;
      if (!done && !busy) nbad++;
      if (done && busy) nbad++;
      if ((eng_start || eng_busy) &&
          ({ram_en, ram_a, ram_we, ram_di} !==
           {eng_en, eng_a, eng_we, eng_di}))
        nbad++;
      if (done) begin
        ncyc = i;
        cyc();
        #1;
        break;
      end
      cyc();
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int ncyc, nst, nrun, nbl, nbad;

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_levels = '0;
    host_req = 1'b0;
    host_bank = '0;
    host_addr = '0;
    host_we = '0;
    host_wdata = '0;
    eng_stuck = 1'b0;
    eng_en = 3'b101;
    eng_a = {9'd11, 9'd22, 9'd33};
    eng_we = 12'hF0F;
    eng_di = 96'h1111_2222_3333_4444_5555_6666;

    cyc();
    cyc();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_ram_en", ram_en, 0);

    // host write bank 1 addr 5
    cyc();
    rst_n = 1'b1;
    host_req = 1'b1;
    host_bank = 2'd1;
    host_addr = 9'd5;
    host_we = 4'hF;
    host_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_gnt", host_gnt, 1);
    chk("wr_en", ram_en, 3'b010);
    chk("wr_a", ram_a, {9'd0, 9'd5, 9'd0});
    chk("wr_we", ram_we, 12'h0F0);
    chk("wr_di", ram_di, {32'h0, 32'hDEADBEEF, 32'h0});

    // read it back
    cyc();
    host_we = 4'h0;
    #1;
    chk("rd_gnt", host_gnt, 1);
    chk("rd_rvalid_0", host_rvalid, 0);
    cyc();
    host_req = 1'b0;
    #1;
    chk("rd_rvalid_1", host_rvalid, 1);
    chk("rd_rdata", host_rdata, 32'hDEADBEEF);
    cyc();
    #1;
    chk("rd_rvalid_2", host_rvalid, 0);

    // bank 3 is a granted no-op reading zero
    host_req = 1'b1;
    host_bank = 2'd3;
    #1;
    chk("b3_gnt", host_gnt, 1);
    chk("b3_en", ram_en, 0);
    chk("b3_we", ram_we, 0);
    cyc();
    host_req = 1'b0;
    #1;
    chk("b3_rvalid", host_rvalid, 1);
    chk("b3_rdata", host_rdata, 0);

    // host and command together, command with zero levels
    cyc();
    host_req = 1'b1;
    host_bank = 2'd0;
    host_addr = 9'd7;
    cmd_valid = 1'b1;
    cmd_levels = 3'd0;
    #1;
    chk("pri_gnt", host_gnt, 1);
    chk("pri_ready", cmd_ready, 0);
    cyc();
    host_req = 1'b0;
    #1;
    chk("pri_ready_after", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    #1;
    chk("l0_busy", busy, 1);
    chk("l0_done_1", done, 0);
    chk("l0_start", eng_start, 0);
    cyc();
    #1;
    chk("l0_done_2", done, 1);
    chk("l0_start_2", eng_start, 0);
    chk("l0_idle", busy, 0);
    cyc();
    #1;
    chk("l0_done_3", done, 0);

    // two-level run with host request and command held
    cmd_valid = 1'b1;
    cmd_levels = 3'd2;
    #1;
    chk("l2_ready", cmd_ready, 1);
    cyc();
    host_req = 1'b1;
    host_bank = 2'd2;
    host_addr = 9'd3;
    #1;
    run_until_done(200, ncyc, nst, nrun, nbl, nbad);
    chk("l2_done_cyc", ncyc, 29);
    chk("l2_starts", nst, 6);
    chk("l2_runs", nrun, 2);
    chk("l2_runlen", nbl, 0);
    chk("l2_run_viol", nbad, 0);
    chk("l2_gnt_after", host_gnt, 1);
    chk("l2_ready_after", cmd_ready, 0);
    cyc();
    host_req = 1'b0;
    cmd_valid = 1'b0;

    // reset in WAIT
    cyc();
    host_req = 1'b1;
    host_bank = 2'd1;
    host_addr = 9'd5;
    #1;
    chk("pre_gnt", host_gnt, 1);
    cyc();
    host_req = 1'b0;
    cmd_valid = 1'b1;
    cmd_levels = 3'd3;
    #1;
    chk("pre_rdata", host_rdata, 32'hDEADBEEF);
    chk("l3_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    repeat (5) cyc();
    #1;
    chk("mid_wait_busy", busy, 1);
    chk("mid_wait_start", eng_start, 0);
    chk("mid_wait_mirror", ram_di, eng_di);
    rst_n = 1'b0;
    #1;
    chk("rstlo_en", ram_en, 0);
    chk("rstlo_a", ram_a, 0);
    chk("rstlo_we", ram_we, 0);
    chk("rstlo_di", ram_di, 0);
    cyc();
    #1;
    chk("rstd_busy", busy, 0);
    chk("rstd_start", eng_start, 0);
    chk("rstd_done", done, 0);
    chk("rstd_rdata", host_rdata, 0);
    chk("rstd_rvalid", host_rvalid, 0);
    chk("rstd_err", err, 0);
    cyc();
    rst_n = 1'b1;
    cmd_valid = 1'b1;
    cmd_levels = 3'd1;
    #1;
    chk("post_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    #1;
    run_until_done(100, ncyc, nst, nrun, nbl, nbad);
    chk("l1_done_cyc", ncyc, 15);
    chk("l1_starts", nst, 3);
    chk("l1_run_viol", nbad, 0);

`ifdef SUBSURF_WATCHDOG_EN
    cyc();
    eng_stuck = 1'b1;
    cmd_valid = 1'b1;
    cmd_levels = 3'd1;
    #1;
    chk("wd_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    repeat (18) cyc();
    #1;
    chk("wd_err_pre", err, 0);
    chk("wd_busy_pre", busy, 1);
    cyc();
    #1;
    chk("wd_err", err, 1);
    chk("wd_busy", busy, 0);
    chk("wd_done", done, 0);
    cyc();
    #1;
    chk("wd_done_2", done, 0);
    chk("wd_err_hold", err, 1);
    eng_stuck = 1'b0;
    cmd_valid = 1'b1;
    cmd_levels = 3'd0;
    #1;
    chk("wd_ready_2", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    #1;
    chk("wd_err_clr", err, 0);
`endif

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
